alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 16-bit ALU execution units (arithmetic, logic, compare, shift).
- Accepts operation requests (operands plus 4-bit ALU function) over a valid/ready handshake and buffers them in a small FIFO.
- Pops at most one request per cycle, decodes the function into a one-hot unit enable plus a 2-bit unit function, and drives registered operands to all units.
- Each unit registers its own result one cycle later.

Parameters:
WIDTH, 16, operand width in bits.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
Clk  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous reset, active-high.
In_Valid  input  1  request present on In_A/In_B/In_FUN.
In_Ready  output  1  FIFO can accept; equals !Full.
In_A  input  WIDTH  operand A.
In_B  input  WIDTH  operand B.
In_FUN  input  4  ALU function; [3:2] unit select, [1:0] unit function.
Stall  input  1  downstream hold; when high, no pop occurs.
Out_A  output  WIDTH  registered operand A to units.
Out_B  output  WIDTH  registered operand B to units.
Unit_FUN  output  2  registered In_FUN[1:0] of issued op.
Arith_Enable  output  1  issued op selects arithmetic unit (In_FUN[3:2]=00).
Logic_Enable  output  1  issued op selects logic unit (01).
CMP_Enable  output  1  issued op selects compare unit (10).
SHIFT_Enable  output  1  issued op selects shift unit (11).
Full  output  1  occupancy == DEPTH.
Empty  output  1  occupancy == 0.
Level  output  $clog2(DEPTH)+1  current occupancy.
Issue_Count  output  8  number of ops issued since reset, wraps 255 -> 0.

Behaviour:
- Reset:
  - Synchronous, active-high. While RST=1 at a rising edge, clear the write pointer, read pointer, and Level.
  - Out_A, Out_B, Unit_FUN, all enables, and Issue_Count go to 0.
  - Outputs after reset: Empty=1, Full=0, In_Ready=1.
  - Reset mid-operation discards all buffered requests and the current issue; enables are 0 in the cycle after reset.
- Push:
  - Occurs when In_Valid && In_Ready at an edge. The entry {In_A, In_B, In_FUN} is written at wptr and wptr increments modulo DEPTH.
  - In_Valid while Full is ignored; there is no overwrite.
- Pop/issue:
  - Occurs when !Empty && !Stall at an edge. The head entry is loaded into Out_A/Out_B/Unit_FUN, and exactly one enable is set per In_FUN[3:2]. rptr increments modulo DEPTH and Issue_Count increments.
  - No pop: all four enables are 0 for that cycle. Out_A/Out_B/Unit_FUN hold the last issued values.
- Latency and bypass:
  - No bypass. A request pushed at edge N is issued at edge N+1 at the earliest; enables are visible during cycle N+1..N+2.
  - Units produce results at edge N+2.
- Simultaneous push and pop:
  - Both occur and Level is unchanged.
  - When Full, In_Ready is 0 even if a pop occurs in the same cycle. Ready is derived from registered occupancy only, so no combinational path exists from Stall to In_Ready.
- Level arithmetic: +1 on push only, -1 on pop only, unchanged otherwise. Full and Empty are decoded from Level.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Order is strictly FIFO across the wrap.
- Stall:
  - Affects only popping; pushes continue until Full.
  - Deasserting Stall issues the head at the next edge.
- Enables are one-hot or all-zero at every cycle; never two set.

Test Plan:
1. Reset, then push one op A=16'h00F0, B=16'h0FF0, FUN=4'b0100 at edge 1 -> at edge 2 Logic_Enable=1, Unit_FUN=00, Out_A=00F0, Out_B=0FF0, Issue_Count=1, Empty=1; at edge 3 all enables 0.
2. With Stall=1, push 4 ops with FUN 0000, 0101, 1010, 1111 -> Full=1, In_Ready=0, Level=4, a 5th In_Valid is ignored. Release Stall -> one op per cycle: Arith(00), Logic(01), CMP(10), SHIFT(11) enables in order; Empty after the 4th.
3. Continuous In_Valid every cycle with Stall=0 -> Level stays at 1 after the first push, one issue per cycle, order preserved across more than 8 pushes (pointer wrap).
4. At Full, assert Stall=0 and In_Valid=1 in the same cycle -> pop occurs, push is refused (In_Ready was 0), Level=3 after the edge.
5. With 3 entries buffered and an op issuing, assert RST for one edge -> next cycle all enables 0, Level=0, Empty=1, Issue_Count=0, Out_A=Out_B=0; the old entries never issue.
6. Issue 256 ops -> Issue_Count wraps to 0 on the 256th issue.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Request channel into the ALU issue stage:
// operands plus ALU function on a valid/ready handshake.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             In_Valid;
   logic             In_Ready;
   logic [WIDTH-1:0] In_A;
   logic [WIDTH-1:0] In_B;
   logic [3:0]       In_FUN;

   modport master (
      output In_Valid,
      output In_A,
      output In_B,
      output In_FUN,
      input  In_Ready
   );

   modport slave (
      input  In_Valid,
      input  In_A,
      input  In_B,
      input  In_FUN,
      output In_Ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: buffers requests in a FIFO and issues one per
// cycle as registered operands plus a one-hot unit enable.
module alu_issue_ctrl #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   RST,
   alu_issue_ctrl_if.slave        req,
   input  logic                   Stall,
   output logic [WIDTH-1:0]       Out_A,
   output logic [WIDTH-1:0]       Out_B,
   output logic [1:0]             Unit_FUN,
   output logic                   Arith_Enable,
   output logic                   Logic_Enable,
   output logic                   CMP_Enable,
   output logic                   SHIFT_Enable,
   output logic                   Full,
   output logic                   Empty,
   output logic [$clog2(DEPTH):0] Level,
   output logic [7:0]             Issue_Count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [3:0]       fun;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            push;
   logic            pop;
   logic [3:0]      en_nxt;
   logic [3:0]      en_q;

   // Ready comes from registered occupancy only, never from Stall.
   assign Full         = (Level == LW'(DEPTH));
   assign Empty        = (Level == '0);
   assign req.In_Ready = !Full;

   assign push = req.In_Valid && !Full;
   assign pop  = !Empty && !Stall;
   assign head = mem[rptr];

   always_comb begin
      en_nxt = 4'b0000;
      if (pop) begin
         unique case (head.fun[3:2])
            2'b00:   en_nxt = 4'b0001;
            2'b01:   en_nxt = 4'b0010;
            2'b10:   en_nxt = 4'b0100;
            default: en_nxt = 4'b1000;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wptr] <= '{a: req.In_A, b: req.In_B, fun: req.In_FUN};
      end
   end

   always_ff @(posedge Clk) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         Level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   Level <= Level + LW'(1);
            2'b01:   Level <= Level - LW'(1);
            default: Level <= Level;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (RST) begin
         Out_A       <= '0;
         Out_B       <= '0;
         Unit_FUN    <= '0;
         en_q        <= '0;
         Issue_Count <= '0;
      end else begin
         en_q <= en_nxt;
         if (pop) begin
            Out_A       <= head.a;
            Out_B       <= head.b;
            Unit_FUN    <= head.fun[1:0];
            Issue_Count <= Issue_Count + 8'd1;
         end
      end
   end

   assign Arith_Enable = en_q[0];
   assign Logic_Enable = en_q[1];
   assign CMP_Enable   = en_q[2];
   assign SHIFT_Enable = en_q[3];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table plus queue scoreboard
// for issue order, enables, occupancy and counter wrap.
module tb_alu_issue_ctrl;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             Clk = 1'b0;
   logic             RST;
   logic             Stall;
   logic [WIDTH-1:0] Out_A;
   logic [WIDTH-1:0] Out_B;
   logic [1:0]       Unit_FUN;
   logic             Arith_Enable;
   logic             Logic_Enable;
   logic             CMP_Enable;
   logic             SHIFT_Enable;
   logic             Full;
   logic             Empty;
   logic [2:0]       Level;
   logic [7:0]       Issue_Count;

   alu_issue_ctrl_if #(.WIDTH(WIDTH)) req ();

   alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .Clk          (Clk),
      .RST          (RST),
      .req          (req),
      .Stall        (Stall),
      .Out_A        (Out_A),
      .Out_B        (Out_B),
      .Unit_FUN     (Unit_FUN),
      .Arith_Enable (Arith_Enable),
      .Logic_Enable (Logic_Enable),
      .CMP_Enable   (CMP_Enable),
      .SHIFT_Enable (SHIFT_Enable),
      .Full         (Full),
      .Empty        (Empty),
      .Level        (Level),
      .Issue_Count  (Issue_Count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  fun;
   } ent_t;

   typedef struct {
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  fun;
      logic        stall;
      logic [3:0]  en;
      int          lvl;
   } vec_t;

   ent_t        sb[$];
   vec_t        tbl[$];
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [1:0]  m_fun;
   logic [3:0]  m_en;
   logic [7:0]  m_cnt;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [3:0] en_vec();
      return {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp,
                  $time);
      end
   endtask

   task automatic step(input logic rst, input logic v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fun, input logic stall);
      ent_t h;
      bit   do_push;
      bit   do_pop;
      @(negedge Clk);
      RST          = rst;
      req.In_Valid = v;
      req.In_A     = a;
      req.In_B     = b;
      req.In_FUN   = fun;
      Stall        = stall;
      #1;
      chk("ready_pre", 32'(req.In_Ready), 32'(sb.size() < DEPTH));
      do_push = v && (sb.size() < DEPTH);
      do_pop  = (sb.size() > 0) && !stall;
      @(posedge Clk);
      #1;
      if (rst) begin
         sb.delete();
         m_a   = '0;
         m_b   = '0;
         m_fun = '0;
         m_en  = '0;
         m_cnt = '0;
      end else begin
         m_en = '0;
         if (do_pop) begin
            h     = sb.pop_front();
            m_a   = h.a;
            m_b   = h.b;
            m_fun = h.fun[1:0];
            m_en  = 4'b0001 << h.fun[3:2];
            m_cnt = m_cnt + 8'd1;
         end
         if (do_push) sb.push_back('{a, b, fun});
      end
      chk("enables", 32'(en_vec()), 32'(m_en));
      chk("out_a", 32'(Out_A), 32'(m_a));
      chk("out_b", 32'(Out_B), 32'(m_b));
      chk("unit_fun", 32'(Unit_FUN), 32'(m_fun));
      chk("level", 32'(Level), 32'(sb.size()));
      chk("empty", 32'(Empty), 32'(sb.size() == 0));
      chk("full", 32'(Full), 32'(sb.size() == DEPTH));
      chk("ready", 32'(req.In_Ready), 32'(sb.size() < DEPTH));
      chk("issue_cnt", 32'(Issue_Count), 32'(m_cnt));
   endtask

   task automatic idle(input logic stall);
      step(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, stall);
   endtask

   initial begin
      RST          = 1'b1;
      Stall        = 1'b0;
      req.In_Valid = 1'b0;
      req.In_A     = '0;
      req.In_B     = '0;
      req.In_FUN   = '0;
      m_cnt        = '0;

      // single op, stalled fill with overflow attempt, pop while full
      tbl.push_back('{1, 16'h00F0, 16'h0FF0, 4'b0100, 0, 4'b0000, 1});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0010, 0});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0000, 0});
      tbl.push_back('{1, 16'h1111, 16'h2222, 4'b0000, 1, 4'b0000, 1});
      tbl.push_back('{1, 16'h3333, 16'h4444, 4'b0101, 1, 4'b0000, 2});
      tbl.push_back('{1, 16'h5555, 16'h6666, 4'b1010, 1, 4'b0000, 3});
      tbl.push_back('{1, 16'h7777, 16'h8888, 4'b1111, 1, 4'b0000, 4});
      tbl.push_back('{1, 16'hDEAD, 16'hBEEF, 4'b0000, 1, 4'b0000, 4});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0001, 3});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0010, 2});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0100, 1});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b1000, 0});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0000, 0});
      tbl.push_back('{1, 16'hA001, 16'hB001, 4'b1000, 1, 4'b0000, 1});
      tbl.push_back('{1, 16'hA002, 16'hB002, 4'b0100, 1, 4'b0000, 2});
      tbl.push_back('{1, 16'hA003, 16'hB003, 4'b1100, 1, 4'b0000, 3});
      tbl.push_back('{1, 16'hA004, 16'hB004, 4'b0001, 1, 4'b0000, 4});
      tbl.push_back('{1, 16'hABCD, 16'h1234, 4'b0000, 0, 4'b0100, 3});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0010, 2});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b1000, 1});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0001, 0});
      tbl.push_back('{0, 16'h0, 16'h0, 4'h0, 0, 4'b0000, 0});

      step(1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
      chk("rst_empty", 32'(Empty), 32'd1);
      chk("rst_level", 32'(Level), 32'd0);

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].fun,
              tbl[i].stall);
         chk($sformatf("tbl%0d_en", i), 32'(en_vec()), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_lvl", i), 32'(Level), 32'(tbl[i].lvl));
      end

      // streaming across pointer wrap
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 16'($urandom), 16'($urandom),
              4'($urandom), 1'b0);
         chk("stream_lvl", 32'(Level), 32'd1);
      end
      idle(1'b0);

      // reset while full and an op is issuing
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 16'(16'hC000 + i), 16'(16'hD000 + i),
              4'(i * 5), 1'b1);
      end
      step(1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
      chk("mid_rst_en", 32'(en_vec()), 32'd0);
      chk("mid_rst_cnt", 32'(Issue_Count), 32'd0);
      chk("mid_rst_a", 32'(Out_A), 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("no_stale_issue", 32'(Issue_Count), 32'd0);

      // 256 issues wrap the counter back to zero
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 1'b1, 16'(i), 16'(~i), 4'(i), 1'b0);
      end
      idle(1'b0);
      chk("cnt_wrap", 32'(Issue_Count), 32'd0);
      idle(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
